temp_poll_scheduler: RTL and testbench

TEMP_POLL_SCHEDULER -- requirements
Module: temp_poll_scheduler

---
 rtl/temp_poll_scheduler.sv | 161 ++++++++++++++++
 tb/tb_temp_poll_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_poll_scheduler.sv
// Periodic round-robin poller for up to four I2C temperature sensors.
// Issues reads, publishes results, and maintains per-channel hysteretic over-temperature alarms.
module temp_poll_scheduler #(
    parameter int                 PERIOD     = 100000,
    parameter int                 TIMEOUT    = 4096,
    parameter logic [6:0]         BASE_ADDR7 = 7'h48,
    parameter logic signed [11:0] HI_THR     = 12'sd400,
    parameter logic signed [11:0] LO_THR     = 12'sd380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  ch_mask,
    output logic        rd_start,
    output logic [7:0]  rd_addr,
    input  logic        rd_done,
    input  logic        rd_err,
    input  logic [15:0] rd_data,
    output logic        temp_valid,
    output logic [1:0]  temp_ch,
    output logic [15:0] temp_data,
    output logic [3:0]  alarm,
    output logic [7:0]  err_cnt,
    output logic        overrun,
    output logic        busy
);
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PW-1:0]      tick_cnt;
    logic               tick;
    logic [TW-1:0]      tmo_cnt;
    logic               timeout_hit;
    logic [1:0]         last_ch;
    logic [1:0]         cur_ch;
    logic [1:0]         sel_ch;
    logic [15:0]        word_q;
    logic signed [11:0] t_val;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            tick_cnt <= '0;
        end else if (tick_cnt == P_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + PW'(1);
        end
    end

    assign tick        = enable && (tick_cnt == P_LAST);
    assign timeout_hit = (tmo_cnt == T_LAST);
    assign t_val       = word_q[15:4];

    // Nearest set mask bit after last_ch; offset 4 wraps back to last_ch itself.
    always_comb begin
        sel_ch = last_ch;
        for (int i = 4; i >= 1; i--) begin
            if (ch_mask[last_ch + 2'(i)]) begin
                sel_ch = last_ch + 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_start = 1'b0;
        busy     = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (tick && (ch_mask != 4'b0000)) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rd_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                // An error (or simultaneous done+err) takes priority over completion.
                if (rd_err || timeout_hit) begin
                    state_d = IDLE;
                end else if (rd_done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_ch    <= 2'd3;
            cur_ch     <= 2'd0;
            rd_addr    <= {BASE_ADDR7, 1'b1};
            tmo_cnt    <= '0;
            word_q     <= 16'h0000;
            temp_valid <= 1'b0;
            temp_ch    <= 2'd0;
            temp_data  <= 16'h0000;
            alarm      <= 4'b0000;
            err_cnt    <= 8'd0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            temp_valid <= 1'b0;
            alarm      <= alarm & ch_mask;
            if (tick && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (state_d == ISSUE) begin
                        cur_ch  <= sel_ch;
                        rd_addr <= {BASE_ADDR7 + 7'(sel_ch), 1'b1};
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                    if (rd_err || timeout_hit) begin
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        last_ch <= cur_ch;
                    end else if (rd_done) begin
                        word_q <= rd_data;
                    end
                end
                UPDATE: begin
                    temp_valid <= 1'b1;
                    temp_ch    <= cur_ch;
                    temp_data  <= word_q;
                    last_ch    <= cur_ch;
                    // Between the thresholds the masked default keeps the previous alarm.
                    if (t_val >= HI_THR) begin
                        alarm[cur_ch] <= ch_mask[cur_ch];
                    end else if (t_val < LO_THR) begin
                        alarm[cur_ch] <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_temp_poll_scheduler.sv
// Directed bench for temp_poll_scheduler: three instances cover normal polling,
// reader timeout, and tick overrun; a shared reader model answers each one.
module tb_temp_poll_scheduler;
    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  en;
    logic [2:0]  rd_done;
    logic [2:0]  rd_err;
    logic [2:0]  rd_start;
    logic [2:0]  temp_valid;
    logic [2:0]  overrun;
    logic [2:0]  busy;
    logic [3:0]  mask      [3];
    logic [15:0] rd_data   [3];
    logic [7:0]  rd_addr   [3];
    logic [1:0]  temp_ch   [3];
    logic [15:0] temp_data [3];
    logic [3:0]  alarm     [3];
    logic [7:0]  err_cnt   [3];

    // Reader model controls: mode 0 done, 1 silent, 2 err, 3 done+err.
    int          rdr_mode  [3];
    int          rdr_lat   [3];
    logic [15:0] rdr_word  [3];
    int          rdr_cnt   [3];
    int          starts    [3] = '{0, 0, 0};

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [1:0] ch_q[$];

    temp_poll_scheduler #(.PERIOD(16), .TIMEOUT(64)) u_main (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .ch_mask(mask[0]),
        .rd_start(rd_start[0]), .rd_addr(rd_addr[0]), .rd_done(rd_done[0]),
        .rd_err(rd_err[0]), .rd_data(rd_data[0]), .temp_valid(temp_valid[0]),
        .temp_ch(temp_ch[0]), .temp_data(temp_data[0]), .alarm(alarm[0]),
        .err_cnt(err_cnt[0]), .overrun(overrun[0]), .busy(busy[0])
    );

    temp_poll_scheduler #(.PERIOD(16), .TIMEOUT(8)) u_tmo (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .ch_mask(mask[1]),
        .rd_start(rd_start[1]), .rd_addr(rd_addr[1]), .rd_done(rd_done[1]),
        .rd_err(rd_err[1]), .rd_data(rd_data[1]), .temp_valid(temp_valid[1]),
        .temp_ch(temp_ch[1]), .temp_data(temp_data[1]), .alarm(alarm[1]),
        .err_cnt(err_cnt[1]), .overrun(overrun[1]), .busy(busy[1])
    );

    temp_poll_scheduler #(.PERIOD(4), .TIMEOUT(64)) u_ovr (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .ch_mask(mask[2]),
        .rd_start(rd_start[2]), .rd_addr(rd_addr[2]), .rd_done(rd_done[2]),
        .rd_err(rd_err[2]), .rd_data(rd_data[2]), .temp_valid(temp_valid[2]),
        .temp_ch(temp_ch[2]), .temp_data(temp_data[2]), .alarm(alarm[2]),
        .err_cnt(err_cnt[2]), .overrun(overrun[2]), .busy(busy[2])
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reader model: pulse rdr_lat cycles after the ISSUE cycle, driven on negedges.
    initial begin
        rd_done = 3'b000;
        rd_err  = 3'b000;
        for (int k = 0; k < 3; k++) begin
            rd_data[k] = 16'h0000;
            rdr_cnt[k] = -1;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                rd_done[k] = 1'b0;
                rd_err[k]  = 1'b0;
                if (rdr_cnt[k] > 0) begin
                    rdr_cnt[k] = rdr_cnt[k] - 1;
                    if (rdr_cnt[k] == 0) begin
                        rd_data[k] = rdr_word[k];
                        rd_done[k] = (rdr_mode[k] != 2);
                        rd_err[k]  = (rdr_mode[k] >= 2);
                        rdr_cnt[k] = -1;
                    end
                end else if (rd_start[k] && rdr_mode[k] != 1) begin
                    rdr_cnt[k] = rdr_lat[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_start[k] === 1'b1) starts[k] = starts[k] + 1;
        end
    end

    // Driver tasks
    task automatic wait_start(input int k, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = (rd_start[k] === 1'b1);
        end
    endtask

    task automatic wait_valid(input int k, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = (temp_valid[k] === 1'b1);
        end
    endtask

    task automatic wait_starts(input int k, input int target, input int limit, output bit ok);
        ok = (starts[k] >= target);
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clk);
            ok = (starts[k] >= target);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        int n;
        rst = 3'b111;
        en  = 3'b111;
        for (int k = 0; k < 3; k++) begin
            mask[k]     = 4'hF;
            rdr_mode[k] = 0;
            rdr_lat[k]  = 10;
            rdr_word[k] = 16'h0000;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++; if (rd_start[k] !== 1'b0) begin errors++; $display("FAIL reset_rd_start[%0d]: got %b want 0", k, rd_start[k]); end
            checks++; if (rd_addr[k] !== 8'h91) begin errors++; $display("FAIL reset_rd_addr[%0d]: got %h want 91", k, rd_addr[k]); end
            checks++; if (temp_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_temp_valid[%0d]: got %b want 0", k, temp_valid[k]); end
            checks++; if (temp_ch[k] !== 2'd0) begin errors++; $display("FAIL reset_temp_ch[%0d]: got %0d want 0", k, temp_ch[k]); end
            checks++; if (temp_data[k] !== 16'h0000) begin errors++; $display("FAIL reset_temp_data[%0d]: got %h want 0000", k, temp_data[k]); end
            checks++; if (alarm[k] !== 4'b0000) begin errors++; $display("FAIL reset_alarm[%0d]: got %b want 0000", k, alarm[k]); end
            checks++; if (err_cnt[k] !== 8'd0) begin errors++; $display("FAIL reset_err_cnt[%0d]: got %0d want 0", k, err_cnt[k]); end
            checks++; if (overrun[k] !== 1'b0) begin errors++; $display("FAIL reset_overrun[%0d]: got %b want 0", k, overrun[k]); end
            checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]); end
        end
        rst = 3'b000;
        en  = 3'b000;
        mask[1] = 4'h0;
        mask[2] = 4'h0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_start[0]) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL enable_low_no_poll: got %0d starts want 0", n); end
        en[0]   = 1'b1;
        mask[0] = 4'h0;
        n = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_start[0] || busy[0]) n++;
        end
        checks++; if (n !== 0) begin errors++; $display("FAIL empty_mask_no_poll: got %0d busy cycles want 0", n); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int nv;
        logic [7:0] exp_addr;
        logic [1:0] exp_ch;
        exp_q.push_back(8'h91); exp_q.push_back(8'h95); exp_q.push_back(8'h91);
        ch_q.push_back(2'd0);   ch_q.push_back(2'd2);   ch_q.push_back(2'd0);
        rdr_word[0] = 16'h0100;
        mask[0]     = 4'b0101;
        for (int p = 0; p < 3; p++) begin
            exp_addr = exp_q.pop_front();
            exp_ch   = ch_q.pop_front();
            wait_start(0, 40, ok);
            checks++; if (!ok || rd_addr[0] !== exp_addr) begin errors++; $display("FAIL rr_addr[%0d]: got %h (seen=%0d) want %h", p, rd_addr[0], ok, exp_addr); end
            wait_valid(0, 30, ok);
            checks++; if (!ok || temp_ch[0] !== exp_ch) begin errors++; $display("FAIL rr_temp_ch[%0d]: got %0d (seen=%0d) want %0d", p, temp_ch[0], ok, exp_ch); end
            checks++; if (temp_data[0] !== 16'h0100) begin errors++; $display("FAIL rr_temp_data[%0d]: got %h want 0100", p, temp_data[0]); end
        end
        checks++; if (alarm[0] !== 4'b0000) begin errors++; $display("FAIL rr_alarm: got %b want 0000", alarm[0]); end
        nv = 0;
        repeat (64) begin
            @(negedge clk);
            if (temp_valid[0]) nv++;
        end
        checks++; if (nv !== 4) begin errors++; $display("FAIL rr_valid_per_tick: got %0d pulses want 4", nv); end
    endtask

    task automatic test_alarm_hysteresis();
        bit ok;
        logic [15:0] words [4];
        logic [3:0]  exp_al [4];
        words[0] = 16'h1A00; exp_al[0] = 4'b0010;
        words[1] = 16'h1800; exp_al[1] = 4'b0010;
        words[2] = 16'h1700; exp_al[2] = 4'b0000;
        words[3] = 16'h1A00; exp_al[3] = 4'b0010;
        wait_valid(0, 30, ok);
        checks++; if (!ok) begin errors++; $display("FAIL alarm_sync: got no temp_valid want one"); end
        mask[0]     = 4'b0010;
        rdr_word[0] = words[0];
        for (int i = 0; i < 4; i++) begin
            wait_valid(0, 30, ok);
            checks++; if (!ok || temp_ch[0] !== 2'd1) begin errors++; $display("FAIL alarm_ch[%0d]: got %0d (seen=%0d) want 1", i, temp_ch[0], ok); end
            checks++; if (temp_data[0] !== words[i]) begin errors++; $display("FAIL alarm_data[%0d]: got %h want %h", i, temp_data[0], words[i]); end
            checks++; if (alarm[0] !== exp_al[i]) begin errors++; $display("FAIL alarm_bits[%0d]: got %b want %b", i, alarm[0], exp_al[i]); end
            if (i < 3) rdr_word[0] = words[i + 1];
        end
    endtask

    task automatic test_err_both();
        bit ok;
        int nv;
        rdr_mode[0] = 3;
        rdr_word[0] = 16'hBEEF;
        wait_start(0, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL both_start: got no rd_start want one"); end
        nv = 0;
        repeat (14) begin
            @(negedge clk);
            if (temp_valid[0]) nv++;
        end
        rdr_mode[0] = 0;
        checks++; if (err_cnt[0] !== 8'd1) begin errors++; $display("FAIL both_err_cnt: got %0d want 1", err_cnt[0]); end
        checks++; if (temp_data[0] !== 16'h1A00) begin errors++; $display("FAIL both_temp_data: got %h want 1A00", temp_data[0]); end
        checks++; if (alarm[0] !== 4'b0010) begin errors++; $display("FAIL both_alarm: got %b want 0010", alarm[0]); end
        checks++; if (nv !== 0) begin errors++; $display("FAIL both_no_valid: got %0d pulses want 0", nv); end
        // Dropping channel 1 from the mask clears its alarm on the next cycle.
        mask[0] = 4'b0001;
        @(negedge clk);
        checks++; if (alarm[0] !== 4'b0000) begin errors++; $display("FAIL mask_clears_alarm: got %b want 0000", alarm[0]); end
    endtask

    task automatic test_timeout();
        bit ok;
        int nb;
        int nv;
        bit dropped;
        rdr_mode[1] = 1;
        mask[1]     = 4'b0001;
        en[1]       = 1'b1;
        wait_start(1, 40, ok);
        checks++; if (!ok || rd_addr[1] !== 8'h91) begin errors++; $display("FAIL tmo_start: got %h (seen=%0d) want 91", rd_addr[1], ok); end
        nb = 0;
        nv = 0;
        dropped = 1'b0;
        for (int i = 0; i < 20 && !dropped; i++) begin
            @(negedge clk);
            if (temp_valid[1]) nv++;
            if (busy[1]) nb++;
            else dropped = 1'b1;
        end
        checks++; if (nb !== 8) begin errors++; $display("FAIL tmo_busy_cycles: got %0d want 8", nb); end
        checks++; if (err_cnt[1] !== 8'd1) begin errors++; $display("FAIL tmo_err_cnt: got %0d want 1", err_cnt[1]); end
        checks++; if (nv !== 0) begin errors++; $display("FAIL tmo_no_valid: got %0d pulses want 0", nv); end
        checks++; if (temp_data[1] !== 16'h0000) begin errors++; $display("FAIL tmo_temp_data: got %h want 0000", temp_data[1]); end
    endtask

    task automatic test_err_saturation();
        bit ok;
        int targets [3];
        logic [7:0] exp_err [3];
        targets[0] = 254; exp_err[0] = 8'd254;
        targets[1] = 255; exp_err[1] = 8'd255;
        targets[2] = 300; exp_err[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            wait_starts(1, targets[i], 6000, ok);
            repeat (12) @(negedge clk);
            checks++; if (!ok || err_cnt[1] !== exp_err[i]) begin errors++; $display("FAIL sat_err_cnt[%0d]: got %0d (reached=%0d) want %0d", targets[i], err_cnt[1], ok, exp_err[i]); end
        end
        en[1] = 1'b0;
    endtask

    task automatic test_overrun();
        int nv;
        logic [1:0] chs [2];
        chs[0] = 2'd3;
        chs[1] = 2'd3;
        rdr_word[2] = 16'h0200;
        mask[2]     = 4'b0011;
        en[2]       = 1'b1;
        nv = 0;
        repeat (60) begin
            @(negedge clk);
            if (temp_valid[2]) begin
                if (nv < 2) chs[nv] = temp_ch[2];
                nv++;
            end
        end
        checks++; if (overrun[2] !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun[2]); end
        checks++; if ((nv >= 2) !== 1'b1) begin errors++; $display("FAIL ovr_polling_continues: got %0d pulses want >=2", nv); end
        checks++; if (chs[0] !== 2'd0 || chs[1] !== 2'd1) begin errors++; $display("FAIL ovr_channel_order: got %0d,%0d want 0,1", chs[0], chs[1]); end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        int nv;
        int nb;
        wait_start(2, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_start: got no rd_start want one"); end
        repeat (3) @(negedge clk);
        rst[2] = 1'b1;
        en[2]  = 1'b0;
        @(negedge clk);
        checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy[2]); end
        checks++; if (overrun[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_overrun: got %b want 0", overrun[2]); end
        rst[2] = 1'b0;
        nv = 0;
        nb = 0;
        repeat (20) begin
            @(negedge clk);
            if (temp_valid[2]) nv++;
            if (busy[2]) nb++;
        end
        checks++; if (nv !== 0) begin errors++; $display("FAIL rst_mid_late_done: got %0d pulses want 0", nv); end
        checks++; if (nb !== 0) begin errors++; $display("FAIL rst_mid_stays_idle: got %0d busy cycles want 0", nb); end
        checks++; if (temp_data[2] !== 16'h0000) begin errors++; $display("FAIL rst_mid_temp_data: got %h want 0000", temp_data[2]); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_alarm_hysteresis();
        test_err_both();
        test_timeout();
        test_err_saturation();
        test_overrun();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
